// File: rtl/prefetch_sched_pkg.sv
// Shared types and default widths for the prefetch/demand AR scheduler.
// Defaults match the prefetcherTop configuration.
package prefetch_sched_pkg;

  localparam int AR_ADDR_BITS    = 16;
  localparam int AR_LEN_WIDTH    = 8;
  localparam int AR_TID_WIDTH    = 8;
  localparam int AR_FRQ_WIDTH    = 6;
  localparam int AR_OUTSTND_W    = 4;
  localparam int AR_STARVE_LIMIT = 8;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_t;

  typedef enum logic {
    SRC_DEMAND,
    SRC_PREFETCH
  } arb_src_t;

  typedef struct packed {
    logic [AR_ADDR_BITS-1:0] addr;
    logic [AR_LEN_WIDTH-1:0] len;
    logic [AR_TID_WIDTH-1:0] id;
  } ar_req_t;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/prefetch_ar_arbiter_if.sv
// Request, AR and R-monitor signals between the requesters, the arbiter and DDR.
// The slave modport is the arbiter's view; master is the surrounding system.
interface prefetch_ar_arbiter_if
  import prefetch_sched_pkg::*;
#(
  parameter int ADDR_BITS       = AR_ADDR_BITS,
  parameter int BURST_LEN_WIDTH = AR_LEN_WIDTH,
  parameter int TID_WIDTH       = AR_TID_WIDTH
);

  logic                       d_valid;
  logic                       d_ready;
  logic [ADDR_BITS-1:0]       d_addr;
  logic [BURST_LEN_WIDTH-1:0] d_len;
  logic [TID_WIDTH-1:0]       d_id;

  logic                       p_valid;
  logic                       p_ready;
  logic [ADDR_BITS-1:0]       p_addr;
  logic [BURST_LEN_WIDTH-1:0] p_len;
  logic [TID_WIDTH-1:0]       p_id;

  logic                       m_ar_valid;
  logic                       m_ar_ready;
  logic [ADDR_BITS-1:0]       m_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] m_ar_len;
  logic [TID_WIDTH-1:0]       m_ar_id;
  logic                       m_ar_isPrefetch;

  logic                       m_r_valid;
  logic                       m_r_ready;
  logic                       m_r_last;

  modport slave (
    input  d_valid, d_addr, d_len, d_id,
    output d_ready,
    input  p_valid, p_addr, p_len, p_id,
    output p_ready,
    output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_ar_isPrefetch,
    input  m_ar_ready,
    input  m_r_valid, m_r_ready, m_r_last
  );

  modport master (
    output d_valid, d_addr, d_len, d_id,
    input  d_ready,
    output p_valid, p_addr, p_len, p_id,
    input  p_ready,
    input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_ar_isPrefetch,
    output m_ar_ready,
    output m_r_valid, m_r_ready, m_r_last
  );

endinterface

// File: rtl/ar_credit_counter.sv
// Outstanding-read counter: +1 per accepted AR, -1 per completed burst,
// saturating at both ends, with a sticky flag for a completion at zero.
module ar_credit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_underflow
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             r_underflow;
  logic             w_underflow_hit;

  always_comb begin
    w_count_next    = r_count;
    w_underflow_hit = i_dec && (r_count == '0);
    case ({i_inc, i_dec})
      2'b10: if (r_count != '1) w_count_next = r_count + 1'b1;
      2'b01: if (r_count != '0) w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_underflow_hit) r_underflow <= 1'b1;
    end
  end

  assign o_count     = r_count;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/prefetch_ar_arbiter.sv
// Arbitrates the single DDR AR channel between demand and prefetch reads.
// Demand wins by default; prefetch is spaced, credit-limited and starvation-guarded.
module prefetch_ar_arbiter
  import prefetch_sched_pkg::*;
#(
  parameter int ADDR_BITS         = AR_ADDR_BITS,
  parameter int BURST_LEN_WIDTH   = AR_LEN_WIDTH,
  parameter int TID_WIDTH         = AR_TID_WIDTH,
  parameter int PRFETCH_FRQ_WIDTH = AR_FRQ_WIDTH,
  parameter int OUTSTND_WIDTH     = AR_OUTSTND_W,
  parameter int STARVE_LIMIT      = AR_STARVE_LIMIT
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         en,
  input  logic [PRFETCH_FRQ_WIDTH-1:0] crs_prefetch_freq,
  input  logic [OUTSTND_WIDTH-1:0]     crs_maxOutstanding,
  output logic [OUTSTND_WIDTH-1:0]     outstanding,
  output logic                         err_underflow,
  prefetch_ar_arbiter_if.slave         bus
);

  localparam int STARVE_W = cnt_width(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t r_state;
  arb_state_t w_state_next;
  ar_req_t    r_req;
  ar_req_t    w_req_next;
  arb_src_t   r_src;
  arb_src_t   w_src_next;

  logic [PRFETCH_FRQ_WIDTH-1:0] r_freq_cnt;
  logic [STARVE_W-1:0]          r_starve_cnt;

  logic                       w_slot_free;
  logic                       w_cred_ok;
  logic                       w_freq_ok;
  logic                       w_p_elig;
  logic                       w_grant_p;
  logic                       w_grant_d;
  logic                       w_r_done;
  logic [ADDR_BITS-1:0]       w_sel_addr;
  logic [BURST_LEN_WIDTH-1:0] w_sel_len;
  logic [TID_WIDTH-1:0]       w_sel_id;

  assign w_slot_free = (r_state == IDLE) || bus.m_ar_ready;
  assign w_cred_ok   = en && (outstanding < crs_maxOutstanding);
  assign w_freq_ok   = (crs_prefetch_freq == '0) || (r_freq_cnt >= crs_prefetch_freq);
  assign w_p_elig    = bus.p_valid && w_cred_ok && w_freq_ok;
  assign w_grant_p   = w_slot_free && w_p_elig &&
                       (!bus.d_valid || (r_starve_cnt == STARVE_MAX));
  assign w_grant_d   = w_slot_free && bus.d_valid && w_cred_ok && !w_grant_p;
  assign w_r_done    = bus.m_r_valid && bus.m_r_ready && bus.m_r_last;

  assign bus.d_ready = w_grant_d;
  assign bus.p_ready = w_grant_p;

  assign w_sel_addr = w_grant_p ? bus.p_addr : bus.d_addr;
  assign w_sel_len  = w_grant_p ? bus.p_len  : bus.d_len;
  assign w_sel_id   = w_grant_p ? bus.p_id   : bus.d_id;

  // A grant always (re)loads the output register, which also covers the
  // back-to-back case where the held AR leaves in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_src_next   = r_src;
    if (w_grant_p || w_grant_d) begin
      w_state_next = HOLD;
      w_req_next   = '{addr: w_sel_addr, len: w_sel_len, id: w_sel_id};
      w_src_next   = w_grant_p ? SRC_PREFETCH : SRC_DEMAND;
    end else if ((r_state == HOLD) && bus.m_ar_ready) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_src   <= SRC_DEMAND;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
      r_src   <= w_src_next;
    end
  end

  // Spacing counter starts saturated so the first prefetch is not delayed.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_freq_cnt   <= '1;
      r_starve_cnt <= '0;
    end else begin
      if (w_grant_p) begin
        r_freq_cnt <= '0;
      end else if (r_freq_cnt != '1) begin
        r_freq_cnt <= r_freq_cnt + 1'b1;
      end

      if (w_grant_p) begin
        r_starve_cnt <= '0;
      end else if (w_p_elig && bus.d_valid && w_grant_d && (r_starve_cnt != STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  ar_credit_counter #(
    .WIDTH (OUTSTND_WIDTH)
  ) u_credit (
    .clk         (clk),
    .resetN      (resetN),
    .i_inc       (w_grant_p || w_grant_d),
    .i_dec       (w_r_done),
    .o_count     (outstanding),
    .o_underflow (err_underflow)
  );

  assign bus.m_ar_valid      = (r_state == HOLD);
  assign bus.m_ar_addr       = r_req.addr;
  assign bus.m_ar_len        = r_req.len;
  assign bus.m_ar_id         = r_req.id;
  assign bus.m_ar_isPrefetch = (r_src == SRC_PREFETCH);

endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// Directed bench for prefetch_ar_arbiter: priority, starvation guard, spacing,
// credit limit, AR stall behaviour, enable gating, underflow and async reset.
module tb_prefetch_ar_arbiter;
  import prefetch_sched_pkg::*;

  logic       clk = 1'b0;
  logic       resetN;
  logic       en;
  logic [5:0] freq;
  logic [3:0] max_out;
  logic [3:0] outstanding;
  logic       err_underflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prefetch_ar_arbiter_if bus ();

  prefetch_ar_arbiter dut (
    .clk                (clk),
    .resetN             (resetN),
    .en                 (en),
    .crs_prefetch_freq  (freq),
    .crs_maxOutstanding (max_out),
    .outstanding        (outstanding),
    .err_underflow      (err_underflow),
    .bus                (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.d_valid    = 1'b0;
    bus.d_addr     = '0;
    bus.d_len      = '0;
    bus.d_id       = '0;
    bus.p_valid    = 1'b0;
    bus.p_addr     = '0;
    bus.p_len      = '0;
    bus.p_id       = '0;
    bus.m_ar_ready = 1'b0;
    bus.m_r_valid  = 1'b0;
    bus.m_r_ready  = 1'b0;
    bus.m_r_last   = 1'b0;
  endtask

  task automatic do_reset();
    resetN  = 1'b0;
    idle_inputs();
    en      = 1'b1;
    freq    = 6'd0;
    max_out = 4'd4;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  task automatic r_beat(input logic on);
    bus.m_r_valid = on;
    bus.m_r_ready = on;
    bus.m_r_last  = on;
  endtask

  // One line per AR handed to DDR.
  always @(negedge clk) begin
    if (resetN && bus.m_ar_valid && bus.m_ar_ready)
      $display("AR issue addr=%04h len=%0d id=%02h prefetch=%0d outstanding=%0d",
               bus.m_ar_addr, bus.m_ar_len, bus.m_ar_id, bus.m_ar_isPrefetch, outstanding);
  end

  initial begin
    resetN = 1'b0;
    idle_inputs();
    en = 1'b0; freq = '0; max_out = '0;

    // First prefetch after reset is immediately eligible.
    do_reset();
    freq = 6'd10; max_out = 4'd4;
    #1;
    check("rst_ar_valid",  32'(bus.m_ar_valid), 32'(0));
    check("rst_ar_addr",   32'(bus.m_ar_addr), 32'(0));
    check("rst_ar_isPf",   32'(bus.m_ar_isPrefetch), 32'(0));
    check("rst_outstand",  32'(outstanding), 32'(0));
    check("rst_underflow", 32'(err_underflow), 32'(0));
    bus.p_valid = 1'b1; bus.p_addr = 16'h0eef; bus.p_len = 8'h03; bus.p_id = 8'h5a;
    #1;
    check("first_p_ready", 32'(bus.p_ready), 32'(1));
    check("first_d_ready", 32'(bus.d_ready), 32'(0));
    step();
    bus.p_valid = 1'b0;
    #1;
    check("first_ar_valid", 32'(bus.m_ar_valid), 32'(1));
    check("first_ar_addr",  32'(bus.m_ar_addr), 32'h0eef);
    check("first_ar_len",   32'(bus.m_ar_len), 32'h03);
    check("first_ar_id",    32'(bus.m_ar_id), 32'h5a);
    check("first_ar_isPf",  32'(bus.m_ar_isPrefetch), 32'(1));
    check("first_outstand", 32'(outstanding), 32'(1));

    // Starvation guard: 8 demand wins, one forced prefetch, then demand again.
    do_reset();
    freq = 6'd0; max_out = 4'd15; bus.m_ar_ready = 1'b1;
    bus.d_valid = 1'b1; bus.d_addr = 16'h1000;
    bus.p_valid = 1'b1; bus.p_addr = 16'h2000;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("starve_d_c%0d", c), 32'(bus.d_ready), 32'(c != 8));
      check($sformatf("starve_p_c%0d", c), 32'(bus.p_ready), 32'(c == 8));
      check($sformatf("starve_src_c%0d", c), 32'(bus.m_ar_isPrefetch), 32'(c == 9));
      step();
    end

    // Prefetch spacing: accepts 11 cycles apart with freq=10.
    do_reset();
    freq = 6'd10; max_out = 4'd15; bus.m_ar_ready = 1'b1; bus.p_valid = 1'b1;
    for (int c = 0; c < 35; c++) begin
      #1;
      check($sformatf("freq_p_c%0d", c), 32'(bus.p_ready), 32'((c % 11) == 0));
      step();
    end

    // Credit limit of 2: third demand waits for one R last.
    do_reset();
    max_out = 4'd2; freq = 6'd0; bus.m_ar_ready = 1'b1;
    bus.d_valid = 1'b1; bus.d_addr = 16'h3000;
    #1;
    check("cred_d0", 32'(bus.d_ready), 32'(1));
    step(); #1;
    check("cred_d1", 32'(bus.d_ready), 32'(1));
    check("cred_out1", 32'(outstanding), 32'(1));
    step(); #1;
    check("cred_d2_blocked", 32'(bus.d_ready), 32'(0));
    check("cred_out2", 32'(outstanding), 32'(2));
    step();
    r_beat(1'b1);
    #1;
    check("cred_d3_blocked", 32'(bus.d_ready), 32'(0));
    step();
    r_beat(1'b0);
    #1;
    check("cred_out_after_r", 32'(outstanding), 32'(1));
    check("cred_d4_accept", 32'(bus.d_ready), 32'(1));
    step();
    bus.d_valid = 1'b0;
    #1;
    check("cred_out_final", 32'(outstanding), 32'(2));
    check("cred_ar_valid", 32'(bus.m_ar_valid), 32'(1));

    // AR stall: held request stays stable, no new accepts until ready.
    do_reset();
    max_out = 4'd4; freq = 6'd0;
    bus.d_valid = 1'b1; bus.d_addr = 16'h1234; bus.d_len = 8'h07; bus.d_id = 8'h11;
    #1;
    check("hold_first_accept", 32'(bus.d_ready), 32'(1));
    step();
    bus.d_addr = 16'h5678; bus.d_id = 8'h22;
    bus.p_valid = 1'b1; bus.p_addr = 16'habcd;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold_valid_%0d", i), 32'(bus.m_ar_valid), 32'(1));
      check($sformatf("hold_addr_%0d", i), 32'(bus.m_ar_addr), 32'h1234);
      check($sformatf("hold_id_%0d", i), 32'(bus.m_ar_id), 32'h11);
      check($sformatf("hold_d_ready_%0d", i), 32'(bus.d_ready), 32'(0));
      check($sformatf("hold_p_ready_%0d", i), 32'(bus.p_ready), 32'(0));
      step();
    end
    bus.m_ar_ready = 1'b1;
    #1;
    check("hold_release_d_ready", 32'(bus.d_ready), 32'(1));
    step();
    bus.d_valid = 1'b0; bus.p_valid = 1'b0;
    #1;
    check("b2b_valid", 32'(bus.m_ar_valid), 32'(1));
    check("b2b_addr", 32'(bus.m_ar_addr), 32'h5678);
    check("b2b_id", 32'(bus.m_ar_id), 32'h22);
    check("b2b_outstand", 32'(outstanding), 32'(2));
    step(); #1;
    check("b2b_idle", 32'(bus.m_ar_valid), 32'(0));

    // Enable gating.
    do_reset();
    en = 1'b0; bus.d_valid = 1'b1; bus.p_valid = 1'b1;
    #1;
    check("en0_d_ready", 32'(bus.d_ready), 32'(0));
    check("en0_p_ready", 32'(bus.p_ready), 32'(0));
    step(); #1;
    check("en0_ar_valid", 32'(bus.m_ar_valid), 32'(0));
    en = 1'b1;
    #1;
    check("en1_d_ready", 32'(bus.d_ready), 32'(1));
    check("en1_p_ready", 32'(bus.p_ready), 32'(0));

    // Underflow is sticky; async reset clears a held AR.
    do_reset();
    r_beat(1'b1);
    step();
    r_beat(1'b0);
    #1;
    check("uf_set", 32'(err_underflow), 32'(1));
    check("uf_outstand", 32'(outstanding), 32'(0));
    repeat (3) step();
    #1;
    check("uf_sticky", 32'(err_underflow), 32'(1));
    bus.m_ar_ready = 1'b0; bus.d_valid = 1'b1; bus.d_addr = 16'h4321;
    step();
    bus.d_valid = 1'b0;
    #1;
    check("arst_pre_valid", 32'(bus.m_ar_valid), 32'(1));
    #2;
    resetN = 1'b0;
    #1;
    check("arst_ar_valid", 32'(bus.m_ar_valid), 32'(0));
    check("arst_ar_addr", 32'(bus.m_ar_addr), 32'(0));
    check("arst_outstand", 32'(outstanding), 32'(0));
    check("arst_underflow", 32'(err_underflow), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
